// File: rtl/rw_retire_ctrl.sv
// Retirement controller: ages allocated matcher slots in insertion order and strobes deletes.
// Optional build macro RW_RETIRE_STATS_EN adds a 32-bit retire_count output.
module rw_retire_ctrl #(
   parameter int QUEUE_LEN = 64,
   parameter int LOC_WIDTH = 6,
   parameter int LIFETIME  = 16,
   parameter int TS_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 insert_success,
   input  logic [LOC_WIDTH-1:0] insert_loc,
   input  logic                 flush_req,
   output logic                 valid_delete,
   output logic [LOC_WIDTH-1:0] del_loc,
   output logic [LOC_WIDTH:0]   occupancy,
   output logic                 flush_done,
   output logic                 overflow_err
`ifdef RW_RETIRE_STATS_EN
   ,
   output logic [31:0]          retire_count
`endif
);

   localparam int CNT_W = LOC_WIDTH + 1;
   localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(QUEUE_LEN);
   localparam logic [TS_WIDTH-1:0] LIFE_TS  = TS_WIDTH'(LIFETIME);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t               state_reg, state_next;
   logic                 flush_done_reg, flush_done_next;
   logic [TS_WIDTH-1:0]  ts_cnt_reg;
   logic [LOC_WIDTH-1:0] head_reg, tail_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic                 valid_delete_reg;
   logic [LOC_WIDTH-1:0] del_loc_reg;
   logic                 overflow_reg;

   // Head must be examined in the cycle it becomes eligible, so storage is read asynchronously.
   logic [LOC_WIDTH-1:0] loc_mem [QUEUE_LEN];
   logic [TS_WIDTH-1:0]  ts_mem  [QUEUE_LEN];

   logic [LOC_WIDTH-1:0] head_loc;
   logic [TS_WIDTH-1:0]  head_age;
   logic                 flush_mode;
   logic                 retire;
   logic                 accept;
   logic                 drop;

   always_comb begin
      head_loc   = loc_mem[head_reg];
      head_age   = ts_cnt_reg - ts_mem[head_reg];
      flush_mode = (state_reg == FLUSH) || flush_req;
      retire     = (cnt_reg != '0) && (flush_mode || (head_age >= LIFE_TS));
      accept     = insert_success && ((cnt_reg != FULL_CNT) || retire);
      drop       = insert_success && (cnt_reg == FULL_CNT) && !retire;
   end

   always_comb begin
      state_next      = state_reg;
      flush_done_next = 1'b0;
      case (state_reg)
         RUN: begin
            if (flush_req) state_next = FLUSH;
         end
         FLUSH: begin
            if ((cnt_reg == '0) && !insert_success) begin
               state_next      = RUN;
               flush_done_next = 1'b1;
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n && accept) begin
         loc_mem[tail_reg] <= insert_loc;
         ts_mem[tail_reg]  <= ts_cnt_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg        <= RUN;
         flush_done_reg   <= 1'b0;
         ts_cnt_reg       <= '0;
         head_reg         <= '0;
         tail_reg         <= '0;
         cnt_reg          <= '0;
         valid_delete_reg <= 1'b0;
         del_loc_reg      <= '0;
         overflow_reg     <= 1'b0;
      end else begin
         state_reg        <= state_next;
         flush_done_reg   <= flush_done_next;
         ts_cnt_reg       <= ts_cnt_reg + TS_WIDTH'(1);
         valid_delete_reg <= retire;
         del_loc_reg      <= retire ? head_loc : '0;
         overflow_reg     <= overflow_reg | drop;
         if (accept) tail_reg <= tail_reg + LOC_WIDTH'(1);
         if (retire) head_reg <= head_reg + LOC_WIDTH'(1);
         if (accept && !retire)      cnt_reg <= cnt_reg + CNT_W'(1);
         else if (!accept && retire) cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

   assign valid_delete = valid_delete_reg;
   assign del_loc      = del_loc_reg;
   assign flush_done   = flush_done_reg;
   assign overflow_err = overflow_reg;
   // A slot stays counted until its delete strobe has actually been presented to the matcher.
   assign occupancy    = cnt_reg + CNT_W'(valid_delete_reg);

`ifdef RW_RETIRE_STATS_EN
   logic [31:0] retire_count_reg;

   always_ff @(posedge clk) begin
      if (!rst_n)                retire_count_reg <= '0;
      else if (valid_delete_reg) retire_count_reg <= retire_count_reg + 32'd1;
   end

   assign retire_count = retire_count_reg;
`endif

endmodule

// File: tb/tb_rw_retire_ctrl.sv
// Self-checking bench for rw_retire_ctrl: directed vector table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_rw_retire_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // default configuration
   logic a_ins, a_fl, a_vd, a_fd, a_ovf;
   logic [5:0] a_loc, a_dl;
   logic [6:0] a_occ;
   // small queue, narrow wrapping timestamp
   logic b_ins, b_fl, b_vd, b_fd, b_ovf;
   logic [2:0] b_loc, b_dl;
   logic [3:0] b_occ;
   // long lifetime so the tracker can be filled
   logic c_ins, c_fl, c_vd, c_fd, c_ovf;
   logic [5:0] c_loc, c_dl;
   logic [6:0] c_occ;

   rw_retire_ctrl dut_a (
      .clk(clk), .rst_n(rst_n), .insert_success(a_ins), .insert_loc(a_loc), .flush_req(a_fl),
      .valid_delete(a_vd), .del_loc(a_dl), .occupancy(a_occ), .flush_done(a_fd), .overflow_err(a_ovf));

   rw_retire_ctrl #(.QUEUE_LEN(8), .LOC_WIDTH(3), .LIFETIME(10), .TS_WIDTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .insert_success(b_ins), .insert_loc(b_loc), .flush_req(b_fl),
      .valid_delete(b_vd), .del_loc(b_dl), .occupancy(b_occ), .flush_done(b_fd), .overflow_err(b_ovf));

   rw_retire_ctrl #(.QUEUE_LEN(64), .LOC_WIDTH(6), .LIFETIME(200), .TS_WIDTH(16)) dut_c (
      .clk(clk), .rst_n(rst_n), .insert_success(c_ins), .insert_loc(c_loc), .flush_req(c_fl),
      .valid_delete(c_vd), .del_loc(c_dl), .occupancy(c_occ), .flush_done(c_fd), .overflow_err(c_ovf));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int ph;
      int t;
      bit ins;
      int loc;
      bit fl;
      bit vd;
      int dl;
      int occ;
      bit fd;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input int ph, input int t, input bit ins, input int loc, input bit fl,
                               input bit vd, input int dl, input int occ, input bit fd);
      vec_t v;
      v = '{ph, t, ins, loc, fl, vd, dl, occ, fd};
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_all();
      a_ins = 0; a_loc = '0; a_fl = 0;
      b_ins = 0; b_loc = '0; b_fl = 0;
      c_ins = 0; c_loc = '0; c_fl = 0;
   endtask

   task automatic do_reset();
      idle_all();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
   endtask

   // reference model state (random phase, dut_b: QUEUE_LEN 8, LIFETIME 10)
   int m_loc[$];
   int m_t[$];
   bit m_flush, m_vd, m_fd, m_ovf;
   int m_dl;

   initial begin
      rst_n = 0;
      idle_all();

      // phase 0: single insert latency and occupancy window
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 10, 1, 5, 0, 0, 0, 0, 0);
      add(0, 11, 0, 0, 0, 0, 0, 1, 0);
      add(0, 26, 0, 0, 0, 0, 0, 1, 0);
      add(0, 27, 0, 0, 0, 1, 5, 1, 0);
      add(0, 28, 0, 0, 0, 0, 0, 0, 0);
      // phase 1: back-to-back inserts retire in order
      add(1, 0, 1, 3, 0, 0, 0, 0, 0);
      add(1, 1, 1, 7, 0, 0, 0, 1, 0);
      add(1, 2, 1, 9, 0, 0, 0, 2, 0);
      add(1, 3, 0, 0, 0, 0, 0, 3, 0);
      add(1, 16, 0, 0, 0, 0, 0, 3, 0);
      add(1, 17, 0, 0, 0, 1, 3, 3, 0);
      add(1, 18, 0, 0, 0, 1, 7, 2, 0);
      add(1, 19, 0, 0, 0, 1, 9, 1, 0);
      add(1, 20, 0, 0, 0, 0, 0, 0, 0);
      // phase 2: flush of four pending entries, then back to normal ageing
      add(2, 0, 1, 1, 0, 0, 0, 0, 0);
      add(2, 1, 1, 2, 0, 0, 0, 1, 0);
      add(2, 2, 1, 4, 0, 0, 0, 2, 0);
      add(2, 3, 1, 8, 0, 0, 0, 3, 0);
      add(2, 5, 0, 0, 1, 0, 0, 4, 0);
      add(2, 6, 0, 0, 0, 1, 1, 4, 0);
      add(2, 7, 0, 0, 0, 1, 2, 3, 0);
      add(2, 8, 0, 0, 0, 1, 4, 2, 0);
      add(2, 9, 0, 0, 0, 1, 8, 1, 0);
      add(2, 10, 0, 0, 0, 0, 0, 0, 1);
      add(2, 11, 0, 0, 0, 0, 0, 0, 0);
      add(2, 12, 1, 20, 0, 0, 0, 0, 0);
      add(2, 13, 0, 0, 0, 0, 0, 1, 0);
      add(2, 28, 0, 0, 0, 0, 0, 1, 0);
      add(2, 29, 0, 0, 0, 1, 20, 1, 0);
      add(2, 30, 0, 0, 0, 0, 0, 0, 0);
      // phase 3: flush of an empty tracker
      add(3, 0, 0, 0, 0, 0, 0, 0, 0);
      add(3, 2, 0, 0, 1, 0, 0, 0, 0);
      add(3, 3, 0, 0, 0, 0, 0, 0, 0);
      add(3, 4, 0, 0, 0, 0, 0, 0, 1);
      add(3, 5, 0, 0, 0, 0, 0, 0, 0);
      add(3, 6, 1, 9, 0, 0, 0, 0, 0);
      add(3, 7, 0, 0, 0, 0, 0, 1, 0);
      add(3, 22, 0, 0, 0, 0, 0, 1, 0);
      add(3, 23, 0, 0, 0, 1, 9, 1, 0);
      add(3, 24, 0, 0, 0, 0, 0, 0, 0);

      for (int ph = 0; ph < 4; ph++) begin
         automatic int last = 0;
         foreach (tbl[i]) if (tbl[i].ph == ph && tbl[i].t > last) last = tbl[i].t;
         do_reset();
         for (int t = 0; t <= last + 1; t++) begin
            automatic int r = -1;
            foreach (tbl[i]) if (tbl[i].ph == ph && tbl[i].t == t) r = i;
            a_ins = 0; a_loc = '0; a_fl = 0;
            if (r >= 0) begin
               chk("tbl_valid_delete", int'(a_vd), int'(tbl[r].vd));
               chk("tbl_del_loc", int'(a_dl), tbl[r].dl);
               chk("tbl_occupancy", int'(a_occ), tbl[r].occ);
               chk("tbl_flush_done", int'(a_fd), int'(tbl[r].fd));
               chk("tbl_overflow", int'(a_ovf), 0);
               a_ins = tbl[r].ins;
               a_loc = 6'(tbl[r].loc);
               a_fl  = tbl[r].fl;
            end else begin
               chk("idle_valid_delete", int'(a_vd), 0);
               chk("idle_flush_done", int'(a_fd), 0);
            end
            tick();
         end
      end

      // timestamp wrap: insert at ts_cnt 12 of a 4-bit counter, retired at ts_cnt 6
      do_reset();
      for (int t = 0; t <= 26; t++) begin
         chk("wrap_valid_delete", int'(b_vd), (t == 23) ? 1 : 0);
         chk("wrap_del_loc", int'(b_dl), (t == 23) ? 5 : 0);
         chk("wrap_occupancy", int'(b_occ), (t >= 13 && t <= 23) ? 1 : 0);
         b_ins = (t == 12);
         b_loc = 3'd5;
         tick();
      end
      b_ins = 0;

      // overflow: fill 64 slots, 65th insert dropped, error sticky until reset
      do_reset();
      for (int t = 0; t < 64; t++) begin
         c_ins = 1;
         c_loc = 6'(t);
         tick();
      end
      chk("full_occupancy", int'(c_occ), 64);
      chk("full_overflow_pre", int'(c_ovf), 0);
      c_loc = 6'd42;
      tick();
      c_ins = 0;
      chk("ovf_set", int'(c_ovf), 1);
      chk("ovf_occupancy", int'(c_occ), 64);
      for (int t = 0; t < 10; t++) tick();
      chk("ovf_sticky", int'(c_ovf), 1);
      chk("ovf_occ_hold", int'(c_occ), 64);
      chk("ovf_no_delete", int'(c_vd), 0);
      do_reset();
      chk("ovf_reset_clear", int'(c_ovf), 0);
      chk("ovf_reset_occ", int'(c_occ), 0);

      // reset in the middle of a flush discards pending entries silently
      do_reset();
      for (int t = 0; t < 5; t++) begin
         a_ins = 1;
         a_loc = 6'(10 + t);
         tick();
      end
      a_ins = 0;
      a_fl = 1;
      tick();
      a_fl = 0;
      chk("midflush_del0", int'(a_dl), 10);
      tick();
      chk("midflush_del1", int'(a_dl), 11);
      chk("midflush_occ", int'(a_occ), 4);
      rst_n = 0;
      tick();
      rst_n = 1;
      for (int t = 0; t < 20; t++) begin
         chk("postrst_valid_delete", int'(a_vd), 0);
         chk("postrst_occupancy", int'(a_occ), 0);
         chk("postrst_flush_done", int'(a_fd), 0);
         tick();
      end

      // randomized run on the small configuration against the queue model
      do_reset();
      m_loc.delete(); m_t.delete();
      m_flush = 0; m_vd = 0; m_fd = 0; m_ovf = 0; m_dl = 0;
      for (int k = 0; k < 3000; k++) begin
         automatic bit r_rst = ($urandom_range(0, 199) != 0);
         automatic bit r_ins = ($urandom_range(0, 99) < 55);
         automatic int r_loc = $urandom_range(0, 7);
         automatic bit r_fl  = ($urandom_range(0, 99) < 3);
         chk("rnd_valid_delete", int'(b_vd), int'(m_vd));
         chk("rnd_del_loc", int'(b_dl), m_dl);
         chk("rnd_occupancy", int'(b_occ), m_loc.size() + int'(m_vd));
         chk("rnd_flush_done", int'(b_fd), int'(m_fd));
         chk("rnd_overflow", int'(b_ovf), int'(m_ovf));
         rst_n = r_rst;
         b_ins = r_ins;
         b_loc = 3'(r_loc);
         b_fl  = r_fl;
         if (!r_rst) begin
            m_loc.delete(); m_t.delete();
            m_flush = 0; m_vd = 0; m_fd = 0; m_ovf = 0; m_dl = 0;
         end else begin
            automatic int  n   = m_loc.size();
            automatic bit  ret = (n > 0) && (m_flush || r_fl || (k - m_t[0] >= 10));
            automatic bit  nvd = ret;
            automatic int  ndl = ret ? m_loc[0] : 0;
            automatic bit  nfd = 0;
            if (ret) begin
               void'(m_loc.pop_front());
               void'(m_t.pop_front());
            end
            if (r_ins) begin
               if (n == 8 && !ret) m_ovf = 1;
               else begin
                  m_loc.push_back(r_loc);
                  m_t.push_back(k);
               end
            end
            if (!m_flush) begin
               if (r_fl) m_flush = 1;
            end else if (n == 0 && !r_ins) begin
               m_flush = 0;
               nfd = 1;
            end
            m_vd = nvd;
            m_dl = ndl;
            m_fd = nfd;
         end
         tick();
      end
      rst_n = 1;
      idle_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rw_retire_ctrl.md
RW_RETIRE_CTRL -- requirements
Module: rw_retire_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- QUEUE_LEN, 64, tracker depth; power of two; equals table slot count.
- LOC_WIDTH, 6, slot index width; log2(QUEUE_LEN).
- LIFETIME, 16, minimum age in cycles before a slot is retired; 1..2^TS_WIDTH-1.
- TS_WIDTH, 16, timestamp counter width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst_n, in, 1, reset; synchronous, active-low.
- insert_success, in, 1, slot allocated this cycle (matcher insert result).
- insert_loc, in, LOC_WIDTH, allocated slot index; valid only with insert_success.
- flush_req, in, 1, single-cycle request to retire all tracked slots regardless of age.
- valid_delete, out, 1, delete strobe to the matcher; registered.
- del_loc, out, LOC_WIDTH, slot to free; valid only with valid_delete, else 0.
- occupancy, out, LOC_WIDTH+1, number of tracked slots.
- flush_done, out, 1, one-cycle pulse when a flush completes.
- overflow_err, out, 1, sticky; an insert arrived while the tracker was full.

Function
REQ-003 Free-running counter ts_cnt (TS_WIDTH) SHALL increment every cycle and wrap modulo 2^TS_WIDTH.
REQ-004 On insert_success, {insert_loc, ts_cnt} SHALL be written at the tail of a circular FIFO of QUEUE_LEN entries; tail pointer wraps QUEUE_LEN-1 -> 0.
REQ-005 Head entry SHALL be eligible when tracker non-empty and (ts_cnt - head_ts) mod 2^TS_WIDTH >= LIFETIME.
REQ-006 At most one entry SHALL be retired per cycle; on retirement, head pops and valid_delete=1, del_loc=head_loc in the following cycle.
REQ-007 Latency: insert accepted in cycle t SHALL produce its valid_delete in cycle t+LIFETIME+1 if it is head and not in FLUSH.
REQ-008 Retirement order SHALL be insertion order; an eligible entry behind an ineligible head SHALL wait.
REQ-009 Simultaneous insert and retire SHALL both take effect; occupancy unchanged.
REQ-010 Insert while occupancy == QUEUE_LEN with no retire that cycle SHALL be dropped and set overflow_err; with a retire that cycle, insert SHALL be accepted.
REQ-011 Retirement with occupancy 0 SHALL never occur; an insert into an empty tracker SHALL NOT be eligible in the same cycle.
REQ-012 FSM states RUN, FLUSH. RUN -> FLUSH on flush_req. In FLUSH the head SHALL retire every cycle regardless of age. FLUSH -> RUN when occupancy reaches 0 with no insert that cycle; flush_done pulses in the cycle after that transition.
REQ-013 Inserts during FLUSH SHALL be accepted and also flushed; flush_req during FLUSH SHALL be ignored.
REQ-014 flush_req with occupancy 0 SHALL enter FLUSH and leave next cycle, flush_done pulsing once.

Reset
REQ-015 While rst_n=0 at a clock edge: FIFO pointers, occupancy, ts_cnt = 0; FSM = RUN; valid_delete, del_loc, flush_done, overflow_err = 0.
REQ-016 Reset mid-FLUSH or with pending entries SHALL discard all entries without emitting deletes; FIFO storage contents need not be cleared.
REQ-017 Inputs during reset cycles SHALL be ignored.

Configuration
REQ-018 Macro RW_RETIRE_STATS_EN: when defined, SHALL add output retire_count (32 bits), counting valid_delete pulses, wrapping at 2^32, reset to 0; when undefined, port and counter SHALL be absent and all other behaviour identical.

Verification
REQ-019 LIFETIME=16: insert loc 5 at cycle 10 -> valid_delete=1, del_loc=5 only at cycle 27; occupancy 1 during cycles 11..27, 0 from 28.
REQ-020 Inserts loc 3,7,9 at cycles 0,1,2 -> deletes 3,7,9 in cycles 17,18,19 in order.
REQ-021 Four entries pending, flush_req at cycle 5 -> four consecutive deletes cycles 6..9, flush_done at cycle 10, state RUN.
REQ-022 Fill 64 entries, insert 65th with no retire -> dropped, overflow_err=1 held until reset; occupancy stays 64.
REQ-023 TS_WIDTH=4, LIFETIME=10, insert at ts_cnt=12 -> retired when ts_cnt wraps to 6 (age 10), del_loc correct.
REQ-024 rst_n low for one cycle with 3 entries mid-FLUSH -> no further valid_delete, occupancy=0, flush_done never pulses.
